// File: rtl/traffic_timer_pkg.sv
// Shared types for the traffic timer: channel state encoding and
// countdown mode constants.
package traffic_timer_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        CH_IDLE = ST_IDLE,
        CH_RUN  = ST_RUN
    } ch_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/traffic_timer_ch.sv
// One countdown channel: counts prescaler ticks down from a loaded value,
// pulses expire when the count runs out, then reloads or goes idle.
module traffic_timer_ch
    import traffic_timer_pkg::*;
#(
    parameter int SEC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    output logic [SEC_W-1:0] remain,
    output logic             expire,
    output ch_state_t        state
);

    logic [0:0]       state_q;
    logic [SEC_W-1:0] remain_q;
    logic [SEC_W-1:0] reload_q;
    logic             mode_q;
    logic             expire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            expire_q <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            if (load) begin
                // A load wins over a coincident tick, so no expiry is reported.
                remain_q <= load_val;
                reload_q <= load_val;
                mode_q   <= auto_reload;
                state_q  <= (load_val != '0) ? ST_RUN : ST_IDLE;
            end else if (state_q == ST_RUN && tick && !pause) begin
                if (remain_q > SEC_W'(1)) begin
                    remain_q <= remain_q - SEC_W'(1);
                end else begin
                    expire_q <= 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        remain_q <= reload_q;
                    end else begin
                        remain_q <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign remain = remain_q;
    assign expire = expire_q;
    assign state  = ch_state_t'(state_q);

endmodule

// File: rtl/traffic_timer.sv
// Shared tick prescaler feeding NUM_CH independent countdown channels
// used to time traffic-light phases.
module traffic_timer
    import traffic_timer_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int NUM_CH  = 4,
    parameter int SEC_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*SEC_W-1:0] load_val,
    input  logic [NUM_CH-1:0]       auto_reload,
    input  logic [NUM_CH-1:0]       pause,
    output logic                    tick,
    output logic                    tick_pre,
    output logic [NUM_CH*SEC_W-1:0] remain,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expire
);

    localparam int                PRE_W   = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;

    // rst_n is folded in so neither pulse can appear while reset is held.
    assign tick     = rst_n & en & ~clr & (pre_cnt == '0);
    assign tick_pre = rst_n & en & ~clr & (pre_cnt == PRE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= PRE_MAX;
        end else if (clr) begin
            pre_cnt <= PRE_MAX;
        end else if (tick) begin
            pre_cnt <= PRE_MAX;
        end else if (en) begin
            pre_cnt <= pre_cnt - PRE_W'(1);
        end
    end

    ch_state_t ch_state [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        traffic_timer_ch #(
            .SEC_W(SEC_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .load       (load[gi]),
            .load_val   (load_val[gi*SEC_W +: SEC_W]),
            .auto_reload(auto_reload[gi]),
            .pause      (pause[gi]),
            .remain     (remain[gi*SEC_W +: SEC_W]),
            .expire     (expire[gi]),
            .state      (ch_state[gi])
        );

        assign busy[gi] = (ch_state[gi] == CH_RUN);
    end

endmodule

// File: tb/tb_traffic_timer.sv
// Randomised and directed bench for traffic_timer with a scoreboard fed by
// a tick-counting reference model.
module tb_traffic_timer;

    localparam int CLK_DIV = 4;
    localparam int NUM_CH  = 2;
    localparam int SEC_W   = 8;
    localparam int RW      = NUM_CH * SEC_W;
    localparam int SB_W    = RW + 2 * NUM_CH + 2;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic [NUM_CH-1:0] load;
    logic [RW-1:0]     load_val;
    logic [NUM_CH-1:0] auto_reload;
    logic [NUM_CH-1:0] pause;
    logic              tick;
    logic              tick_pre;
    logic [RW-1:0]     remain;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] expire;

    traffic_timer #(
        .CLK_DIV(CLK_DIV),
        .NUM_CH (NUM_CH),
        .SEC_W  (SEC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .pause      (pause),
        .tick       (tick),
        .tick_pre   (tick_pre),
        .remain     (remain),
        .busy       (busy),
        .expire     (expire)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SB_W-1:0] exp_q[$];

    // reference model: enabled cycles since the last tick, per-channel
    // ticks left, running flag, periodic flag, reload value, pending expiry
    int since;
    int m_rem    [NUM_CH];
    bit m_run    [NUM_CH];
    bit m_per    [NUM_CH];
    int m_reload [NUM_CH];
    bit m_exp    [NUM_CH];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        since = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_rem[c]    = 0;
            m_run[c]    = 1'b0;
            m_per[c]    = 1'b0;
            m_reload[c] = 0;
            m_exp[c]    = 1'b0;
        end
    endtask

    // driver: one clock cycle of stimulus plus the model's prediction
    task automatic step(input logic e, input logic c, input logic [NUM_CH-1:0] ld,
                        input logic [RW-1:0] lv, input logic [NUM_CH-1:0] ar,
                        input logic [NUM_CH-1:0] ps);
        logic [SB_W-1:0]   item;
        logic [NUM_CH-1:0] b_v;
        logic [NUM_CH-1:0] x_v;
        logic [RW-1:0]     r_v;
        bit                t;
        bit                tp;
        int                v;
        @(negedge clk);
        en          = e;
        clr         = c;
        load        = ld;
        load_val    = lv;
        auto_reload = ar;
        pause       = ps;
        t  = e && !c && (since == CLK_DIV - 1);
        tp = e && !c && (since == CLK_DIV - 2);
        for (int k = 0; k < NUM_CH; k++) begin
            b_v[k] = m_run[k];
            x_v[k] = m_exp[k];
            r_v[k*SEC_W +: SEC_W] = SEC_W'(m_rem[k]);
        end
        item = {t, tp, b_v, x_v, r_v};
        exp_q.push_back(item);
        for (int k = 0; k < NUM_CH; k++) begin
            m_exp[k] = 1'b0;
            if (ld[k]) begin
                v           = int'(lv[k*SEC_W +: SEC_W]);
                m_rem[k]    = v;
                m_reload[k] = v;
                m_per[k]    = ar[k];
                m_run[k]    = (v != 0);
            end else if (m_run[k] && t && !ps[k]) begin
                if (m_rem[k] > 1) begin
                    m_rem[k] = m_rem[k] - 1;
                end else begin
                    m_exp[k] = 1'b1;
                    if (m_per[k]) begin
                        m_rem[k] = m_reload[k];
                    end else begin
                        m_rem[k] = 0;
                        m_run[k] = 1'b0;
                    end
                end
            end
        end
        if (c || t) since = 0;
        else if (e) since = since + 1;
    endtask

    task automatic idle_steps(input int n, input logic [NUM_CH-1:0] ps);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, '0, '0, ps);
    endtask

    // step with en high until the model says the next cycle ticks
    task automatic run_to_tick();
        for (int k = 0; k < 2 * CLK_DIV && since != CLK_DIV - 1; k++)
            step(1'b1, 1'b0, '0, '0, '0, '0);
        check("align_to_tick", since, CLK_DIV - 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // monitor: outputs are presented every cycle, compared mid-low-phase
    initial begin
        logic [SB_W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick", int'(tick), int'(e[SB_W-1]));
                check("tick_pre", int'(tick_pre), int'(e[SB_W-2]));
                for (int k = 0; k < NUM_CH; k++) begin
                    check($sformatf("remain[%0d]", k), int'(remain[k*SEC_W +: SEC_W]),
                          int'(e[k*SEC_W +: SEC_W]));
                    check($sformatf("busy[%0d]", k), int'(busy[k]), int'(e[RW+NUM_CH+k]));
                    check($sformatf("expire[%0d]", k), int'(expire[k]), int'(e[RW+k]));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        clr         = 1'b0;
        load        = '0;
        load_val    = '0;
        auto_reload = '0;
        pause       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_remain", int'(remain), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_expire", int'(expire), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_tick_pre", int'(tick_pre), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // prescaler cadence, then a two-cycle enable gap
        idle_steps(3, '0);
        step(1'b0, 1'b0, '0, '0, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0, '0);
        idle_steps(10, '0);

        // one-shot on channel 0
        step(1'b1, 1'b0, 2'b01, {8'd0, 8'd3}, 2'b00, '0);
        idle_steps(20, '0);

        // auto-reload on channel 1
        step(1'b1, 1'b0, 2'b10, {8'd2, 8'd0}, 2'b10, '0);
        idle_steps(24, '0);

        // pause across two ticks, then resume; then clr mid-count
        step(1'b1, 1'b0, 2'b01, {8'd0, 8'd5}, 2'b00, '0);
        idle_steps(2 * CLK_DIV, 2'b01);
        idle_steps(6, '0);
        step(1'b1, 1'b1, '0, '0, '0, '0);
        idle_steps(CLK_DIV + 2, '0);

        // load colliding with the expiring tick, then a zero load
        step(1'b1, 1'b0, 2'b01, {8'd0, 8'd1}, 2'b00, '0);
        run_to_tick();
        step(1'b1, 1'b0, 2'b01, {8'd0, 8'd7}, 2'b00, '0);
        idle_steps(3, '0);
        step(1'b1, 1'b0, 2'b01, {8'd0, 8'd0}, 2'b00, '0);
        idle_steps(2 * CLK_DIV, '0);

        // asynchronous reset in the middle of a run on both channels
        step(1'b1, 1'b0, 2'b11, {8'd9, 8'd6}, 2'b01, '0);
        idle_steps(6, '0);
        drain();
        check("pre_reset_busy", int'(busy), 3);
        rst_n = 1'b0;
        en    = 1'b1;
        #1;
        check("async_remain", int'(remain), 0);
        check("async_busy", int'(busy), 0);
        check("async_expire", int'(expire), 0);
        check("async_tick", int'(tick), 0);
        check("async_tick_pre", int'(tick_pre), 0);
        model_reset();
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        idle_steps(3 * CLK_DIV, '0);

        // randomised traffic
        for (int n = 0; n < 1500; n++) begin
            logic [NUM_CH-1:0] ld;
            logic [NUM_CH-1:0] ar;
            logic [NUM_CH-1:0] ps;
            logic [RW-1:0]     lv;
            for (int k = 0; k < NUM_CH; k++) begin
                ld[k] = ($urandom_range(0, 19) == 0);
                ar[k] = 1'($urandom_range(0, 1));
                ps[k] = ($urandom_range(0, 7) == 0);
                lv[k*SEC_W +: SEC_W] = ($urandom_range(0, 15) == 0)
                                       ? SEC_W'($urandom_range(0, 255))
                                       : SEC_W'($urandom_range(0, 5));
            end
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), ld, lv, ar, ps);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Parametrised successor of the single-channel second-tick prescaler: a shared clock prescaler generates a one-cycle tick every CLK_DIV enabled clocks.
- NUM_CH independent countdown channels count in ticks (phase durations).
- Each channel is loadable, pausable and selectable as one-shot or auto-reload, with a per-channel expire pulse.
- Sits between the system clock and the traffic-light phase FSM, replacing discrete prescaler-plus-phase-counter pairs.

Parameters:
- CLK_DIV, 100, clocks per tick; legal range is CLK_DIV >= 2.
- NUM_CH, 4, number of countdown channels; legal range is >= 1.
- SEC_W, 8, width of each channel's tick count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  prescaler enable; when low, prescaler holds and no ticks occur.
- clr  input  1  synchronous prescaler restart.
- load  input  NUM_CH  per-channel load strobe.
- load_val  input  NUM_CH*SEC_W  load values; channel i uses bits [i*SEC_W +: SEC_W].
- auto_reload  input  NUM_CH  per-channel mode: 1 = periodic, 0 = one-shot; sampled on load.
- pause  input  NUM_CH  per-channel freeze.
- tick  output  1  one-cycle tick pulse.
- tick_pre  output  1  high the cycle before tick.
- remain  output  NUM_CH*SEC_W  per-channel remaining count (registered).
- busy  output  NUM_CH  per-channel running flag.
- expire  output  NUM_CH  per-channel one-cycle expiry pulse (registered).

Behaviour:
- Reset (async, rst_n low):
  - pre_cnt = CLK_DIV-1.
  - All channels IDLE; remain = 0, busy = 0, expire = 0, stored mode = one-shot, stored reload value = 0.
  - tick = 0 and tick_pre = 0 throughout reset.
- Prescaler:
  - pre_cnt width is $clog2(CLK_DIV).
  - tick = en & (pre_cnt == 0); tick_pre = en & (pre_cnt == 1). Both are combinational from the register.
  - Priority on the clock edge, highest first:
    - clr: reload pre_cnt to CLK_DIV-1; tick and tick_pre forced 0 that cycle.
    - tick: reload pre_cnt to CLK_DIV-1.
    - en: decrement pre_cnt.
    - otherwise: hold.
  - First tick occurs in the CLK_DIV-th enabled cycle after reset release.
- Channel FSM, states IDLE and RUN:
  - Load priority: load[i] overrides everything for that channel in that cycle.
    - remain and the stored reload value take load_val; mode takes auto_reload[i]; expire is not raised.
    - Next state is RUN if load_val != 0, otherwise IDLE.
  - RUN, counting: tick & !pause[i] & !load[i] & remain > 1 -> remain decrements by 1.
  - RUN, expiry: tick & !pause[i] & !load[i] & remain == 1 -> expire[i] = 1 in the next cycle.
    - Auto-reload mode: remain takes the stored reload value; state stays RUN.
    - One-shot mode: remain = 0; state goes to IDLE.
  - RUN with pause[i] high: remain and state hold; ticks during pause are lost, not queued.
  - IDLE: ticks are ignored.
  - busy[i] = (state == RUN), registered.
- Latency: a tick in cycle T updates remain, busy and expire, all visible in cycle T+1.
- Arithmetic: remain never wraps below 0; load_val = 0 never produces expire.
- Channels are fully independent; simultaneous expiries on several channels are all reported in the same cycle.

Decomposition:
- traffic_timer_pkg holds:
  - the channel state enum (IDLE, RUN);
  - the mode constants MODE_ONESHOT = 0 and MODE_PERIODIC = 1.
- One sub-module, traffic_timer_ch: a single channel FSM plus counter, instantiated NUM_CH times in a generate loop.
- The prescaler stays inline in traffic_timer.

Test Plan:
All scenarios use CLK_DIV=4, NUM_CH=2, SEC_W=8.
1. Release reset, en=1 -> tick in cycles 3, 7, 11…; tick_pre in cycles 2, 6, 10; en low for 2 cycles before cycle 3 -> tick slips by exactly 2.
2. One-shot: load[0] with val 3 at cycle 0 -> remain 3, 2, 1, 0 after successive ticks; expire[0] high for one cycle as busy[0] falls; no further expiries.
3. Auto-reload: load[1] with val 2 -> expire[1] every 8 clocks; remain sequence 2, 1, 2, 1…; busy[1] stays 1.
4. pause[0] held across two ticks with remain=5 -> remain stays 5; it resumes to 4 on the first tick after pause drops. clr mid-count -> next tick exactly CLK_DIV cycles after clr.
5. load[0] with val 7 in the same cycle as a tick while remain=1 -> no expire, remain=7. load_val=0 -> busy=0 and no expire.
6. Assert rst_n low mid-run on both channels -> remain, busy and expire clear immediately, without a clock edge; prescaler restarts at CLK_DIV-1.
